// File: rtl/demux_1_to_k_buf_if.sv
// Purpose: handshake/bus bundle between one producer, the 1-to-K demux and its K consumers.
// Signals:
//   in_valid/in_ready/in_data/sel : producer stream and destination lane
//   out_valid/out_ready/out_data  : K lane handshakes, lane i at out_data[i*SIZE +: SIZE]
//   sel_err                       : sticky out-of-range select flag
//   acc_cnt                       : count of accepted words
// Modports: master = producer/consumer side, slave = demux.
interface demux_1_to_k_buf_if #(
   parameter int unsigned K    = 4,
   parameter int unsigned SIZE = 16,
   parameter int unsigned CNTW = 16
);
   localparam int unsigned BIT = $clog2(K);

   logic              in_valid;
   logic              in_ready;
   logic [SIZE-1:0]   in_data;
   logic [BIT-1:0]    sel;
   logic [K-1:0]      out_valid;
   logic [K-1:0]      out_ready;
   logic [K*SIZE-1:0] out_data;
   logic              sel_err;
   logic [CNTW-1:0]   acc_cnt;

   modport master (
      output in_valid, in_data, sel, out_ready,
      input  in_ready, out_valid, out_data, sel_err, acc_cnt
   );

   modport slave (
      input  in_valid, in_data, sel, out_ready,
      output in_ready, out_valid, out_data, sel_err, acc_cnt
   );
endinterface

// File: rtl/demux_1_to_k_buf.sv
// Purpose: steers one valid/ready word stream to one of K lanes, each with a 1-entry holding register.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   bus     : demux_1_to_k_buf_if.slave (input stream, K output lanes, sel_err, acc_cnt)
// Configuration macro: DEMUX_AUTO_SEL_EN -- when defined the sel input is ignored and an internal
//   round-robin pointer picks the destination lane; undefined, the sel input picks it.
// in_ready is combinational (depends on sel and out_ready, never on in_valid); all other outputs
// come straight from registers.
module demux_1_to_k_buf #(
   parameter int unsigned K    = 4,
   parameter int unsigned SIZE = 16,
   parameter int unsigned CNTW = 16
) (
   input logic                clk,
   input logic                rst,
   demux_1_to_k_buf_if.slave  bus
);
   localparam int unsigned BIT = $clog2(K);

   logic [K-1:0]      full_q, full_d;
   logic [K*SIZE-1:0] data_q, data_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [BIT-1:0]    dst;
   logic              dst_ok;
   logic              tgt_free;
   logic              acc;

`ifdef DEMUX_AUTO_SEL_EN
   logic [BIT-1:0] ptr_q, ptr_d;
   logic           unused_sel;

   // Round-robin dealer: pointer is always a legal lane.
   assign unused_sel = ^bus.sel;
   assign dst        = ptr_q;
   assign dst_ok     = 1'b1;
   assign ptr_d      = !acc ? ptr_q :
                       (ptr_q == BIT'(K-1)) ? '0 : ptr_q + BIT'(1);

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   // Non-power-of-2 K leaves sel codes with no lane behind them.
   assign dst    = bus.sel;
   assign dst_ok = (32'(bus.sel) < K);
`endif

   // Ready, accept and per-lane next state; accept overrides a same-cycle pop on its lane.
   always_comb begin
      full_d   = full_q & ~bus.out_ready;
      data_d   = data_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      tgt_free = 1'b0;
      if (dst_ok) tgt_free = ~full_q[dst] | bus.out_ready[dst];
      bus.in_ready = dst_ok & tgt_free;
      acc = bus.in_valid & bus.in_ready;
      if (acc) begin
         full_d[dst]                   = 1'b1;
         data_d[32'(dst)*SIZE +: SIZE] = bus.in_data;
         cnt_d                         = cnt_q + CNTW'(1);
      end
      if (bus.in_valid && !dst_ok) err_d = 1'b1;
   end

   // State registers; reset drops any in-flight word.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign bus.out_valid = full_q;
   assign bus.out_data  = data_q;
   assign bus.acc_cnt   = cnt_q;
   assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_demux_1_to_k_buf.sv
// Testbench for demux_1_to_k_buf: driver pushes accepted words into per-lane expectation queues,
// a negedge monitor pops and compares whatever each lane presents.
module tb_demux_1_to_k_buf;
   localparam int unsigned K    = 4;
   localparam int unsigned SIZE = 16;
   localparam int unsigned CNTW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   demux_1_to_k_buf_if #(.K(K), .SIZE(SIZE), .CNTW(CNTW)) bus ();

   demux_1_to_k_buf #(.K(K), .SIZE(SIZE), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model: each lane is a queue of capacity one.
   logic [SIZE-1:0] q [K][$];
   int              pops [K];
   int              pop_lane [$];
   int              cnt_m;
   int              ptr_m;
   int              n_checks = 0;
   int              n_err = 0;
   bit              mon_en = 1'b0;
   bit              rand_rdy = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < K; i++) q[i].delete();
      cnt_m = 0;
      ptr_m = 0;
   endfunction

   // Monitor: compare lane contents and counters, retire words the consumer takes.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < K; i++) begin
            chk($sformatf("out_valid[%0d]", i), 32'(bus.out_valid[i]), 32'(q[i].size() != 0));
            if (q[i].size() > 1) chk("lane_capacity", 32'(q[i].size()), 32'd1);
            if (q[i].size() != 0) begin
               chk($sformatf("out_data[%0d]", i), 32'(bus.out_data[i*SIZE +: SIZE]), 32'(q[i][0]));
               if (bus.out_ready[i]) begin
                  void'(q[i].pop_front());
                  pops[i]++;
                  pop_lane.push_back(i);
               end
            end
         end
         chk("acc_cnt", 32'(bus.acc_cnt), 32'(cnt_m % (1 << CNTW)));
         chk("sel_err", 32'(bus.sel_err), 32'd0);
      end
   end

   // Random consumer backpressure during the random phase.
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.out_ready = K'($urandom);
      end
   end

   // Offer one word until accepted (bounded); in_ready is checked against the model every cycle.
   task automatic send(input int s, input logic [SIZE-1:0] d);
      int  lane;
      bit  ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.sel      = 2'(s);
      bus.in_data  = d;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         #1;
`ifdef DEMUX_AUTO_SEL_EN
         lane = ptr_m;
`else
         lane = s;
`endif
         chk("in_ready", 32'(bus.in_ready), 32'(q[lane].size() == 0));
         if (bus.in_ready) begin
            q[lane].push_back(d);
            cnt_m++;
            ptr_m = (ptr_m + 1) % K;
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) begin
         @(posedge clk);
         clear_model();
      end
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.sel       = '0;
      bus.out_ready = '0;
      for (int i = 0; i < K; i++) pops[i] = 0;
      clear_model();
      @(posedge clk);
      #1;
      apply_reset(2);
      mon_en = 1'b1;

      // Reset state and idle readiness for every sel.
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_acc_cnt", 32'(bus.acc_cnt), 32'd0);
      chk("rst_out_data", 32'(bus.out_data == '0), 32'd1);
      for (int s = 0; s < K; s++) begin
         bus.sel = 2'(s);
         #1;
         chk($sformatf("rst_in_ready_sel%0d", s), 32'(bus.in_ready), 32'd1);
      end
      @(posedge clk);
      #1;

`ifndef DEMUX_AUTO_SEL_EN
      // Routing with consumers always ready: each lane pulses once.
      bus.out_ready = 4'b1111;
      for (int i = 0; i < K; i++) pops[i] = 0;
      send(0, 16'hAAAA);
      send(1, 16'hBBBB);
      send(2, 16'hCCCC);
      send(3, 16'hDDDD);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < K; i++) chk($sformatf("route_pops%0d", i), 32'(pops[i]), 32'd1);
      chk("route_acc_cnt", 32'(bus.acc_cnt), 32'd4);

      // Backpressure on lane 2, then release it while the second word waits.
      bus.out_ready = 4'b0000;
      send(2, 16'h1111);
      fork
         send(2, 16'h2222);
         begin
            repeat (3) @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_lane2_hold", 32'(bus.out_data[2*SIZE +: SIZE]), 32'h1111);
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            bus.out_ready[2] = 1'b1;
         end
      join
      @(negedge clk);
      chk("bp_lane2_new", 32'(bus.out_data[2*SIZE +: SIZE]), 32'h2222);
      @(posedge clk);
      #1;
      bus.out_ready = 4'b0000;

      // Independence: stalled lane 1 does not block lane 3.
      send(1, 16'h5A5A);
      send(3, 16'h3C3C);
      @(negedge clk);
      chk("ind_lane1_data", 32'(bus.out_data[1*SIZE +: SIZE]), 32'h5A5A);
      chk("ind_lane3_data", 32'(bus.out_data[3*SIZE +: SIZE]), 32'h3C3C);
      @(posedge clk);
      #1;
      bus.out_ready = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
`else
      // Round-robin dealing with sel tied to 0.
      bus.out_ready = 4'b1111;
      pop_lane.delete();
      for (int w = 0; w < 6; w++) send(0, 16'(16'h0100 + w));
      repeat (2) @(posedge clk);
      #1;
      chk("rr_count", 32'(pop_lane.size()), 32'd6);
      for (int w = 0; w < 6 && w < pop_lane.size(); w++)
         chk($sformatf("rr_lane%0d", w), 32'(pop_lane[w]), 32'(w % K));
`endif

      // Mid-operation reset with a word offered.
      bus.out_ready = 4'b0000;
      send(0, 16'h0F0F);
      send(3, 16'hF0F0);
      bus.in_valid = 1'b1;
      bus.sel      = 2'd1;
      bus.in_data  = 16'h7777;
      apply_reset(1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_acc_cnt", 32'(bus.acc_cnt), 32'd0);
      @(posedge clk);
      #1;

      // Randomized traffic under random backpressure.
      rand_rdy = 1'b1;
      for (int w = 0; w < 200; w++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
         send(int'($urandom_range(0, K-1)), SIZE'($urandom));
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      bus.out_ready = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
